wb_write_queue: RTL and testbench

//  Writeback-side merge queue between the dual-lane memory stage and the single-write-port regfile.

---
 rtl/wb_write_queue.sv | 113 +++++++++++
 tb/tb_wb_write_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback merge queue: accepts up to two register writes per cycle, retires one per cycle
// in program order onto the regfile port, and bypasses the youngest pending value to decode.
module wb_write_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in0_valid,
  input  logic [4:0]  in0_addr,
  input  logic [31:0] in0_data,
  input  logic        in1_valid,
  input  logic [4:0]  in1_addr,
  input  logic [31:0] in1_data,
  output logic        in_ready,
  output logic        rf_w_en,
  output logic [4:0]  rf_w_addr,
  output logic [31:0] rf_w_data,
  input  logic [4:0]  fwd_ra1,
  input  logic [4:0]  fwd_ra2,
  output logic        fwd_hit1,
  output logic [31:0] fwd_data1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data2,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic [4:0]  addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];

  logic            st0, st1, drain;
  logic [PtrW-1:0] tail_p1;
  logic [PtrW-1:0] idx;

  // Readiness looks only at registered occupancy so it never depends on this cycle's drain.
  assign in_ready = (count_q <= CntW'(DEPTH - 2));
  assign empty    = (count_q == '0);
  assign drain    = !empty;

  // Writes to r0 are accepted but dropped.
  assign st0     = in0_valid && in_ready && (in0_addr != 5'd0);
  assign st1     = in1_valid && in_ready && (in1_addr != 5'd0);
  assign tail_p1 = tail_q + PtrW'(1);

  always_comb begin
    head_d  = head_q + PtrW'(drain);
    tail_d  = tail_q + PtrW'(st0) + PtrW'(st1);
    count_d = count_q + CntW'(st0) + CntW'(st1) - CntW'(drain);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads carry no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (st0) begin
      addr_q[tail_q] <= in0_addr;
      data_q[tail_q] <= in0_data;
    end
    if (st1) begin
      addr_q[st0 ? tail_p1 : tail_q] <= in1_addr;
      data_q[st0 ? tail_p1 : tail_q] <= in1_data;
    end
  end

  always_comb begin
    rf_w_en   = drain;
    rf_w_addr = 5'd0;
    rf_w_data = 32'd0;
    if (drain) begin
      rf_w_addr = addr_q[head_q];
      rf_w_data = data_q[head_q];
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = 32'd0;
    fwd_hit2  = 1'b0;
    fwd_data2 = 32'd0;
    idx       = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PtrW'(k);
      if (CntW'(k) < count_q) begin
        if ((fwd_ra1 != 5'd0) && (addr_q[idx] == fwd_ra1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[idx];
        end
        if ((fwd_ra2 != 5'd0) && (addr_q[idx] == fwd_ra2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboarded bench for wb_write_queue: directed scenarios followed by random traffic,
// checked against a queue-of-pending-writes reference model.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in0_valid = 1'b0, in1_valid = 1'b0;
  logic [4:0]  in0_addr = '0, in1_addr = '0;
  logic [31:0] in0_data = '0, in1_data = '0;
  logic        in_ready, rf_w_en, fwd_hit1, fwd_hit2, empty;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data, fwd_data1, fwd_data2;
  logic [4:0]  fwd_ra1 = '0, fwd_ra2 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Pending writes in acceptance order; front is the next to retire.
  wr_t exp_q[$];
  bit  model_ready = 1'b1;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_addr  (in0_addr),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_addr  (in1_addr),
    .in1_data  (in1_data),
    .in_ready  (in_ready),
    .rf_w_en   (rf_w_en),
    .rf_w_addr (rf_w_addr),
    .rf_w_data (rf_w_data),
    .fwd_ra1   (fwd_ra1),
    .fwd_ra2   (fwd_ra2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_fwd(input logic [4:0] ra, output logic hit,
                                    output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    if (ra != 5'd0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i].addr == ra) begin
          hit = 1'b1;
          d   = exp_q[i].data;
        end
      end
    end
  endfunction

  // Monitor: compare all outputs against the model mid-cycle, then retire the head.
  always @(negedge clk) begin
    logic        h;
    logic [31:0] d;
    if (reset) begin
      model_ready = (DEPTH - exp_q.size()) >= 2;
      chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready});
      chk("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
      chk("rf_w_en", {31'd0, rf_w_en}, {31'd0, exp_q.size() != 0});
      model_fwd(fwd_ra1, h, d);
      chk("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, h});
      chk("fwd_data1", fwd_data1, d);
      model_fwd(fwd_ra2, h, d);
      chk("fwd_hit2", {31'd0, fwd_hit2}, {31'd0, h});
      chk("fwd_data2", fwd_data2, d);
      if (exp_q.size() != 0) begin
        chk("rf_w_addr", {27'd0, rf_w_addr}, {27'd0, exp_q[0].addr});
        chk("rf_w_data", rf_w_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk("rf_w_addr_idle", {27'd0, rf_w_addr}, 32'd0);
        chk("rf_w_data_idle", rf_w_data, 32'd0);
      end
    end
  end

  // Drive one cycle of stimulus; accepted non-r0 requests become expected writes.
  task automatic cycle(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    #1;
    in0_valid = v0; in0_addr = a0; in0_data = d0;
    in1_valid = v1; in1_addr = a1; in1_data = d1;
    fwd_ra1 = r1; fwd_ra2 = r2;
    if (model_ready) begin
      if (v0 && a0 != 5'd0) exp_q.push_back('{addr: a0, data: d0});
      if (v1 && a1 != 5'd0) exp_q.push_back('{addr: a1, data: d1});
    end
  endtask

  task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rf_w_en"}, {31'd0, rf_w_en}, 32'd0);
    chk({tag, "_rf_w_addr"}, {27'd0, rf_w_addr}, 32'd0);
    chk({tag, "_rf_w_data"}, rf_w_data, 32'd0);
    chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_fwd_hit1"}, {31'd0, fwd_hit1}, 32'd0);
    chk({tag, "_fwd_hit2"}, {31'd0, fwd_hit2}, 32'd0);
    chk({tag, "_fwd_data1"}, fwd_data1, 32'd0);
    chk({tag, "_fwd_data2"}, fwd_data2, 32'd0);
  endtask

  initial begin
    fwd_ra1 = 5'd3;
    #3;
    check_reset_outputs("por");
    #19 reset = 1'b1;

    // Single write with bypass on ra1.
    cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    idle(3, 5'd3, 5'd0);

    // Two lanes in one cycle retire lane 0 first.
    cycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 5'd5, 5'd6);
    idle(3, 5'd5, 5'd6);

    // Saturate both lanes to exercise backpressure.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 5'(10 + i), $urandom, 1'b1, 5'(20 + i), $urandom, 5'(10 + i), 5'(20 + i));
    idle(8, 5'd0, 5'd0);

    // r0 writes are dropped; ra=0 never hits.
    cycle(1'b1, 5'd0, 32'hFF, 1'b1, 5'd7, 32'h7, 5'd0, 5'd7);
    idle(3, 5'd0, 5'd7);

    // Duplicate destination: youngest value bypassed, oldest retired first.
    cycle(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
    idle(3, 5'd9, 5'd9);

    // Async reset with three entries pending.
    cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2);
    cycle(1'b1, 5'd1, 32'hB1, 1'b1, 5'd2, 32'hB2, 5'd1, 5'd2);
    @(posedge clk);
    #2;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    model_ready = 1'b1;
    #1 reset = 1'b1;
    idle(4, 5'd1, 5'd2);

    // Random traffic with a small address space to provoke duplicates and r0.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Bounded drain of whatever remains.
    idle(DEPTH + 4, 5'd0, 5'd0);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
